// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the display path. It produces sync, blank,
//   data-enable and line/frame strobes for any CEA/VESA-style mode. The x/y
//   coordinates run LOOKAHEAD pixel ticks ahead of the display position so
//   that the framebuffer has time to return pixel data. The raster stops only
//   at a frame boundary, so a monitor never sees a truncated frame.
//
// Ports
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   en          : run request. It is sampled only on the final tick of a frame
//                 while running, and on any clk while idle.
//   hs, vs      : registered sync outputs. Polarity is set by HS_POL/VS_POL.
//   blank       : high outside the active area, and always high while idle
//   de          : data enable, ~blank while running and 0 while idle
//   x, y        : lookahead pixel coordinate
//   pix_tick    : one-clk pulse per pixel period
//   line_start  : one-clk strobe in the first clk of every line
//   frame_start : one-clk strobe in the first clk of every frame
//   busy        : high while the raster is running
//   frame_cnt   : count of completed frames, wraps

module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int LOOKAHEAD = 1,
  parameter int CW        = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               de,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int PS_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]   H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]   V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]   X_HOME  = CW'(LOOKAHEAD);
  localparam logic            HS_ACT  = (HS_POL != 0);
  localparam logic            VS_ACT  = (VS_POL != 0);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic [CW-1:0]        hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0]        xl_q, xl_d, yl_q, yl_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 hs_q, hs_d, vs_q, vs_d;
  logic                 blank_q, blank_d, de_q, de_d;
  logic                 line_start_q, line_start_d;
  logic                 frame_start_q, frame_start_d;
  logic                 tick, last_tick;

  assign tick      = (state_q == RUN) && (ps_q == PS_LAST);
  assign last_tick = tick && (hc_q == H_LAST) && (vc_q == V_LAST);

  // Next-state logic. The lead counters xl/yl step exactly like hc/vc, so
  // they keep a constant LOOKAHEAD-tick offset from the display position,
  // wrapping across line and frame boundaries. Strobes are produced as
  // next-state values so they appear in the first clk of a line or frame.
  always_comb begin
    state_d       = state_q;
    ps_d          = ps_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    xl_d          = xl_q;
    yl_d          = yl_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        ps_d = '0;
        hc_d = '0;
        vc_d = '0;
        xl_d = X_HOME;
        yl_d = '0;
        if (en) begin
          state_d       = RUN;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end

      RUN: begin
        ps_d = tick ? '0 : ps_q + PS_W'(1);
        if (tick) begin
          xl_d = (xl_q == H_LAST) ? '0 : xl_q + CW'(1);
          if (xl_q == H_LAST) begin
            yl_d = (yl_q == V_LAST) ? '0 : yl_q + CW'(1);
          end

          if (last_tick) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            hc_d        = '0;
            vc_d        = '0;
            if (!en) begin
              // Stop at the frame boundary; lead counters go back home.
              state_d = IDLE;
              ps_d    = '0;
              xl_d    = X_HOME;
              yl_d    = '0;
            end else begin
              line_start_d  = 1'b1;
              frame_start_d = 1'b1;
            end
          end else if (hc_q == H_LAST) begin
            hc_d         = '0;
            vc_d         = vc_q + CW'(1);
            line_start_d = 1'b1;
          end else begin
            hc_d = hc_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Decode from the next counter values so the registered outputs change on
  // the same edge as hc/vc. An idle raster is always blanked with sync
  // inactive.
  always_comb begin
    hs_d    = ~HS_ACT;
    vs_d    = ~VS_ACT;
    blank_d = 1'b1;
    de_d    = 1'b0;
    if (state_d == RUN) begin
      if (int'(hc_d) >= HS_START && int'(hc_d) < HS_END) hs_d = HS_ACT;
      if (int'(vc_d) >= VS_START && int'(vc_d) < VS_END) vs_d = VS_ACT;
      blank_d = (int'(hc_d) >= H_ACTIVE) || (int'(vc_d) >= V_ACTIVE);
      de_d    = ~blank_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ps_q          <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      xl_q          <= X_HOME;
      yl_q          <= '0;
      frame_cnt_q   <= '0;
      hs_q          <= ~HS_ACT;
      vs_q          <= ~VS_ACT;
      blank_q       <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ps_q          <= ps_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      xl_q          <= xl_d;
      yl_q          <= yl_d;
      frame_cnt_q   <= frame_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign de          = de_q;
  assign x           = xl_q;
  assign y           = yl_q;
  assign pix_tick    = tick;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == RUN);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen with three instances:
//     D : default 640x480 mode (reset values, first-line timing, async reset)
//     T : tiny mode H 4/1/1/1, V 3/1/1/1, CLK_DIV 1, active-high syncs
//     S : small mode H 8/2/3/2, V 5/1/2/1, CLK_DIV 3, LOOKAHEAD 2
//   Inputs are driven and outputs sampled on the falling clock edge.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic enD, enT, enS;

  always #5 clk = ~clk;

  logic       hsD, vsD, blankD, deD, pixD, lsD, fsD, busyD;
  logic [9:0] xD, yD;
  logic [7:0] fcD;

  logic       hsT, vsT, blankT, deT, pixT, lsT, fsT, busyT;
  logic [3:0] xT, yT;
  logic [7:0] fcT;

  logic       hsS, vsS, blankS, deS, pixS, lsS, fsS, busyS;
  logic [4:0] xS, yS;
  logic [7:0] fcS;

  int errorCount = 0;
  int checkCount = 0;

  vga_timing_gen dutD (
    .clk(clk), .reset_n(reset_n), .en(enD),
    .hs(hsD), .vs(vsD), .blank(blankD), .de(deD), .x(xD), .y(yD),
    .pix_tick(pixD), .line_start(lsD), .frame_start(fsD), .busy(busyD),
    .frame_cnt(fcD)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1), .VS_POL(1), .LOOKAHEAD(0), .CW(4), .FRAME_W(8)
  ) dutT (
    .clk(clk), .reset_n(reset_n), .en(enT),
    .hs(hsT), .vs(vsT), .blank(blankT), .de(deT), .x(xT), .y(yT),
    .pix_tick(pixT), .line_start(lsT), .frame_start(fsT), .busy(busyT),
    .frame_cnt(fcT)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .HS_POL(0), .VS_POL(0), .LOOKAHEAD(2), .CW(5), .FRAME_W(8)
  ) dutS (
    .clk(clk), .reset_n(reset_n), .en(enS),
    .hs(hsS), .vs(vsS), .blank(blankS), .de(deS), .x(xS), .y(yS),
    .pix_tick(pixS), .line_start(lsS), .frame_start(fsS), .busy(busyS),
    .frame_cnt(fcS)
  );

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives the three run requests together.
  task automatic applyStimulus(input logic d, input logic t, input logic s);
    enD = d;
    enT = t;
    enS = s;
  endtask

  initial begin
    int firstHsLow, hsLowCount, deCount, lineCount, lastLineIdx, pixCount;
    int hsErr, vsErr, blankErr, deErr, xyErr, busyErr, pixErr, lsErr, fsErr, fcErr;
    int hc, vc, p, expFc, fsCount;
    logic run;

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Values while reset is held.
    checkOutput("D busy in reset", busyD, 0);
    checkOutput("D hs in reset", hsD, 1);
    checkOutput("D x in reset", xD, 1);

    reset_n = 1'b1;
    repeat (100) @(negedge clk);

    // Idle with en low for 100 clks.
    checkOutput("D idle hs", hsD, 1);
    checkOutput("D idle vs", vsD, 1);
    checkOutput("D idle blank", blankD, 1);
    checkOutput("D idle de", deD, 0);
    checkOutput("D idle pix_tick", pixD, 0);
    checkOutput("D idle line_start", lsD, 0);
    checkOutput("D idle frame_start", fsD, 0);
    checkOutput("D idle busy", busyD, 0);
    checkOutput("D idle frame_cnt", fcD, 0);
    checkOutput("D idle x", xD, 1);
    checkOutput("D idle y", yD, 0);
    checkOutput("T idle hs", hsT, 0);
    checkOutput("S idle x", xS, 2);

    // Default mode: first line timing.
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    firstHsLow  = -1;
    hsLowCount  = 0;
    deCount     = 0;
    lineCount   = 0;
    lastLineIdx = -1;
    pixCount    = 0;
    for (int i = 0; i <= 1600; i++) begin
      if (i == 0) begin
        checkOutput("D entry frame_start", fsD, 1);
        checkOutput("D entry line_start", lsD, 1);
        checkOutput("D entry busy", busyD, 1);
        checkOutput("D entry blank", blankD, 0);
        checkOutput("D entry de", deD, 1);
        checkOutput("D entry pix_tick", pixD, 0);
        checkOutput("D entry vs", vsD, 1);
        checkOutput("D entry x", xD, 1);
        checkOutput("D entry y", yD, 0);
      end
      if (i == 1) checkOutput("D first pix_tick", pixD, 1);
      if (i == 1274) checkOutput("D x at hc 637", xD, 638);
      if (i < 1600) begin
        if (!hsD) begin
          if (firstHsLow < 0) firstHsLow = i;
          hsLowCount++;
        end
        if (deD) deCount++;
        if (pixD) pixCount++;
      end
      if (i > 0 && lsD) begin
        lineCount++;
        lastLineIdx = i;
      end
      @(negedge clk);
    end
    checkOutput("D hs start after line_start", firstHsLow, 1312);
    checkOutput("D hs low clks", hsLowCount, 192);
    checkOutput("D de clks per line", deCount, 1280);
    checkOutput("D pix_tick per line", pixCount, 800);
    checkOutput("D line_start count", lineCount, 1);
    checkOutput("D line period", lastLineIdx, 1600);

    // Now at sample 1601; move to hc = 300 of line 1 and reset asynchronously.
    repeat (599) @(negedge clk);
    checkOutput("D x before reset", xD, 301);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("D async busy", busyD, 0);
    checkOutput("D async blank", blankD, 1);
    checkOutput("D async de", deD, 0);
    checkOutput("D async x", xD, 1);
    checkOutput("D async y", yD, 0);
    checkOutput("D async pix_tick", pixD, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("D restart frame_start", fsD, 1);
    checkOutput("D restart busy", busyD, 1);
    checkOutput("D restart x", xD, 1);
    checkOutput("D restart y", yD, 0);

    // Tiny mode: 7-clk lines, 42-clk frames, stop after the third frame.
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    hsErr = 0; vsErr = 0; blankErr = 0; deErr = 0; xyErr = 0;
    busyErr = 0; pixErr = 0; lsErr = 0; fsErr = 0; fcErr = 0; fsCount = 0;
    for (int i = 0; i <= 135; i++) begin
      run   = (i <= 125);
      hc    = i % 7;
      vc    = (i / 7) % 6;
      expFc = (i >= 126) ? 3 : (i >= 84) ? 2 : (i >= 42) ? 1 : 0;
      if (hsT !== (run && hc == 5)) hsErr++;
      if (vsT !== (run && vc == 4)) vsErr++;
      if (blankT !== (!run || hc >= 4 || vc >= 3)) blankErr++;
      if (deT !== (run && hc < 4 && vc < 3)) deErr++;
      if (int'(xT) != (run ? hc : 0) || int'(yT) != (run ? vc : 0)) xyErr++;
      if (busyT !== run) busyErr++;
      if (pixT !== run) pixErr++;
      if (lsT !== (run && hc == 0)) lsErr++;
      if (fsT !== (run && hc == 0 && vc == 0)) fsErr++;
      if (int'(fcT) != expFc) fcErr++;
      if (fsT) fsCount++;
      if (i == 5) checkOutput("T hs at hc 5", hsT, 1);
      if (i == 28) checkOutput("T vs on line 4", vsT, 1);
      if (i == 84) enT = 1'b0;
      @(negedge clk);
    end
    checkOutput("T hs pattern errors", hsErr, 0);
    checkOutput("T vs pattern errors", vsErr, 0);
    checkOutput("T blank pattern errors", blankErr, 0);
    checkOutput("T de pattern errors", deErr, 0);
    checkOutput("T xy pattern errors", xyErr, 0);
    checkOutput("T busy pattern errors", busyErr, 0);
    checkOutput("T pix_tick pattern errors", pixErr, 0);
    checkOutput("T line_start pattern errors", lsErr, 0);
    checkOutput("T frame_start pattern errors", fsErr, 0);
    checkOutput("T frame_cnt pattern errors", fcErr, 0);
    checkOutput("T frame_start count", fsCount, 3);

    // Small mode: CLK_DIV 3, LOOKAHEAD 2, en toggles mid-frame then stop.
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    hsErr = 0; vsErr = 0; blankErr = 0; deErr = 0; xyErr = 0;
    busyErr = 0; pixErr = 0; lsErr = 0; fsErr = 0; fcErr = 0; pixCount = 0;
    for (int i = 0; i <= 830; i++) begin
      run   = (i <= 809);
      hc    = (i / 3) % 15;
      vc    = (i / 45) % 9;
      p     = ((i / 3) + 2) % 135;
      expFc = (i >= 810) ? 2 : (i >= 405) ? 1 : 0;
      if (hsS !== !(run && hc >= 10 && hc < 13)) hsErr++;
      if (vsS !== !(run && vc >= 6 && vc < 8)) vsErr++;
      if (blankS !== (!run || hc >= 8 || vc >= 5)) blankErr++;
      if (deS !== (run && hc < 8 && vc < 5)) deErr++;
      if (int'(xS) != (run ? p % 15 : 2) || int'(yS) != (run ? p / 15 : 0)) xyErr++;
      if (busyS !== run) busyErr++;
      if (pixS !== (run && i % 3 == 2)) pixErr++;
      if (lsS !== (run && i % 45 == 0)) lsErr++;
      if (fsS !== (run && i % 405 == 0)) fsErr++;
      if (int'(fcS) != expFc) fcErr++;
      if (i < 405 && pixS) pixCount++;
      if (i == 126) begin
        checkOutput("S x at hc 12 vc 2", xS, 14);
        checkOutput("S y at hc 12 vc 2", yS, 2);
      end
      if (i == 129) begin
        checkOutput("S x at hc 13 vc 2", xS, 0);
        checkOutput("S y at hc 13 vc 2", yS, 3);
      end
      if (i == 402) begin
        checkOutput("S x at last pixel", xS, 1);
        checkOutput("S y at last pixel", yS, 0);
      end
      if (i == 405) checkOutput("S frame_start after toggle", fsS, 1);
      if (i == 135) enS = 1'b0;
      if (i == 270) enS = 1'b1;
      if (i == 540) enS = 1'b0;
      @(negedge clk);
    end
    checkOutput("S hs pattern errors", hsErr, 0);
    checkOutput("S vs pattern errors", vsErr, 0);
    checkOutput("S blank pattern errors", blankErr, 0);
    checkOutput("S de pattern errors", deErr, 0);
    checkOutput("S xy pattern errors", xyErr, 0);
    checkOutput("S busy pattern errors", busyErr, 0);
    checkOutput("S pix_tick pattern errors", pixErr, 0);
    checkOutput("S line_start pattern errors", lsErr, 0);
    checkOutput("S frame_start pattern errors", fsErr, 0);
    checkOutput("S frame_cnt pattern errors", fcErr, 0);
    checkOutput("S pix_tick per frame", pixCount, 135);

    // Re-raise en from idle: frame starts in the very next clk.
    enS = 1'b1;
    @(negedge clk);
    checkOutput("S rerun frame_start", fsS, 1);
    checkOutput("S rerun busy", busyS, 1);
    checkOutput("S rerun pix_tick", pixS, 0);
    checkOutput("S rerun x", xS, 2);
    checkOutput("S rerun frame_cnt", fcS, 2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
